// File: rtl/coin_pulse_conditioner_if.sv
// rtl/coin_pulse_conditioner_if.sv - coin sensor inputs and clean coin pulse outputs
interface coin_pulse_conditioner_if;
  logic raw_n;
  logic raw_d;
  logic raw_q;
  logic accept_en;
  logic clear_err;
  logic n_pulse;
  logic d_pulse;
  logic q_pulse;
  logic rejected;
  logic overflow;

  // Sensor side / stimulus: drives raw levels and control, observes pulses
  modport master (
    output raw_n, raw_d, raw_q, accept_en, clear_err,
    input  n_pulse, d_pulse, q_pulse, rejected, overflow
  );

  // Conditioner side
  modport slave (
    input  raw_n, raw_d, raw_q, accept_en, clear_err,
    output n_pulse, d_pulse, q_pulse, rejected, overflow
  );
endinterface

// File: rtl/coin_pulse_conditioner.sv
// rtl/coin_pulse_conditioner.sv - sync, debounce, queue and serialise coin sensor pulses
module coin_pulse_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 1,
  parameter int PEND_W          = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  coin_pulse_conditioner_if.slave  bus
);
  // Coin index: 0 = nickel, 1 = dime, 2 = quarter (higher index wins)
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  logic [2:0] raw;
  assign raw = {bus.raw_q, bus.raw_d, bus.raw_n};

  logic [SYNC_STAGES-1:0] sync_q [3];
  logic [SYNC_STAGES-1:0] sync_d [3];
  logic [CNT_W-1:0]       cnt_q  [3];
  logic [CNT_W-1:0]       cnt_d  [3];
  logic [PEND_W-1:0]      pend_q [3];
  logic [PEND_W-1:0]      pend_d [3];
  logic [2:0]             deb_q, deb_d, deb_prev_q;
  logic [2:0]             pulse_q, pulse_d;
  logic                   rejected_q, rejected_d;
  logic                   overflow_q, overflow_d;
  state_t                 state_q, state_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;

  logic       any_pend, can_launch, launch;
  logic [2:0] dec;

  // Launch arbitration and serialising FSM: Q > D > N, fixed gap between pulses
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    dec       = 3'b000;
    any_pend  = (pend_q[0] != '0) | (pend_q[1] != '0) | (pend_q[2] != '0);
    can_launch = (state_q == IDLE) ||
                 (state_q == GAP && gap_cnt_q == GAP_W'(1)) ||
                 (state_q == PULSE && GAP_CYCLES == 0);
    launch = can_launch & any_pend;
    if (launch) begin
      if (pend_q[2] != '0)      dec = 3'b100;
      else if (pend_q[1] != '0) dec = 3'b010;
      else                      dec = 3'b001;
    end
    unique case (state_q)
      IDLE: begin
        if (launch) state_d = PULSE;
      end
      PULSE: begin
        if (GAP_CYCLES > 0) begin
          state_d   = GAP;
          gap_cnt_d = GAP_LOAD;
        end else if (launch) begin
          state_d = PULSE;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
        if (gap_cnt_q == GAP_W'(1)) state_d = launch ? PULSE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-coin synchroniser, debounce, edge detect and pending-queue bookkeeping
  always_comb begin
    logic sync_out, rise, full, inc;
    rejected_d = 1'b0;
    overflow_d = overflow_q & ~bus.clear_err;
    deb_d      = deb_q;
    pulse_d    = dec;
    for (int i = 0; i < 3; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw[i]};
      sync_out  = sync_q[i][SYNC_STAGES-1];
      cnt_d[i]  = '0;
      if (sync_out != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) deb_d[i] = sync_out;
        else                      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      rise = deb_q[i] & ~deb_prev_q[i];
      // A counter being drained this cycle has room for the new coin
      full = (pend_q[i] == PEND_MAX) & ~dec[i];
      inc  = rise & bus.accept_en & ~full;
      if (rise & (~bus.accept_en | full)) rejected_d = 1'b1;
      if (rise & bus.accept_en & full)    overflow_d = 1'b1;
      pend_d[i] = pend_q[i];
      if (inc & ~dec[i])      pend_d[i] = pend_q[i] + PEND_W'(1);
      else if (~inc & dec[i]) pend_d[i] = pend_q[i] - PEND_W'(1);
    end
  end

  // State registers; asynchronous reset discards all queued coins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
        pend_q[i] <= '0;
      end
      deb_q      <= '0;
      deb_prev_q <= '0;
      pulse_q    <= '0;
      rejected_q <= 1'b0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      gap_cnt_q  <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        sync_q[i] <= sync_d[i];
        cnt_q[i]  <= cnt_d[i];
        pend_q[i] <= pend_d[i];
      end
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      pulse_q    <= pulse_d;
      rejected_q <= rejected_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign bus.n_pulse  = pulse_q[0];
  assign bus.d_pulse  = pulse_q[1];
  assign bus.q_pulse  = pulse_q[2];
  assign bus.rejected = rejected_q;
  assign bus.overflow = overflow_q;
endmodule
